// File: rtl/alu_divmod_pkg.sv
// alu_divmod_pkg
//   Shared definitions for the sequential eBPF DIV/MOD unit: datapath width,
//   op encodings, FSM state type and the single restoring-division step.
package alu_divmod_pkg;

    localparam int unsigned DATA_W = 64;

    // in_op encoding
    localparam logic OP_DIV = 1'b0;
    localparam logic OP_MOD = 1'b1;

    // Iteration counts per operand class
    localparam logic [6:0] ITER_64 = 7'd64;
    localparam logic [6:0] ITER_32 = 7'd32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic              q_bit;
    } step_t;

    // One restoring-division step: shift the next dividend bit into the
    // partial remainder and keep the trial difference when it does not borrow.
    // The trial is one bit wider than the data so the borrow is visible; since
    // rem < b on entry, the kept remainder always fits back into DATA_W bits.
    function automatic step_t div_step(
        input logic [DATA_W-1:0] rem,
        input logic              a_bit,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] shifted;
        logic [DATA_W:0] trial;
        step_t           r;
        shifted = {rem, a_bit};
        trial   = shifted - {1'b0, b};
        if (trial[DATA_W]) begin
            r.rem   = shifted[DATA_W-1:0];
            r.q_bit = 1'b0;
        end else begin
            r.rem   = trial[DATA_W-1:0];
            r.q_bit = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_divmod_seq.sv
// alu_divmod_seq
//   Sequential unsigned divide / modulo for eBPF ALU32 and ALU64 classes.
//   Restoring division, one quotient bit per clock, MSB first.
//   A zero effective divisor skips iteration: DIV yields 0, MOD yields dst.
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (ready only when idle)
//   in_a, in_b          dividend (dst), divisor (src/imm)
//   in_op               0 = DIV, 1 = MOD
//   in_is32             1 = ALU32 (low 32 bits, zero-extended result)
//   out_valid/out_ready result handshake
//   out_result          quotient or remainder, held while out_valid && !out_ready
module alu_divmod_seq #(
    parameter int unsigned DATA_W = alu_divmod_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_op,
    input  logic              in_is32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result
);
    import alu_divmod_pkg::*;

    localparam int unsigned HALF_W = DATA_W / 2;

    state_t            state;
    logic [6:0]        cnt;
    logic [DATA_W-1:0] a_q;       // dividend, shifted left once per iteration
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] result_q;
    logic              op_q;
    logic              is32_q;

    logic [DATA_W-1:0] eff_a;
    logic [DATA_W-1:0] eff_b;
    logic [DATA_W-1:0] load_a;
    logic [DATA_W-1:0] q_next;
    logic [DATA_W-1:0] fin_result;
    step_t             step;

    always_comb begin
        eff_a = in_is32 ? {{(DATA_W-HALF_W){1'b0}}, in_a[HALF_W-1:0]} : in_a;
        eff_b = in_is32 ? {{(DATA_W-HALF_W){1'b0}}, in_b[HALF_W-1:0]} : in_b;
        // ALU32 dividend is left-aligned so the MSB-first loop needs only 32 steps.
        load_a = in_is32 ? {in_a[HALF_W-1:0], {(DATA_W-HALF_W){1'b0}}} : in_a;
    end

    always_comb begin
        step   = div_step(rem_q, a_q[DATA_W-1], b_q);
        q_next = {q_q[DATA_W-2:0], step.q_bit};
        fin_result = (op_q == OP_MOD) ? step.rem : q_next;
        if (is32_q) begin
            fin_result[DATA_W-1:HALF_W] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            rem_q    <= '0;
            result_q <= '0;
            op_q     <= 1'b0;
            is32_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= load_a;
                        b_q    <= eff_b;
                        q_q    <= '0;
                        rem_q  <= '0;
                        op_q   <= in_op;
                        is32_q <= in_is32;
                        if (eff_b == '0) begin
                            cnt      <= '0;
                            result_q <= (in_op == OP_MOD) ? eff_a : '0;
                            state    <= DONE;
                        end else begin
                            cnt   <= in_is32 ? ITER_32 : ITER_64;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem_q <= step.rem;
                    q_q   <= q_next;
                    a_q   <= {a_q[DATA_W-2:0], 1'b0};
                    cnt   <= cnt - 7'd1;
                    if (cnt == 7'd1) begin
                        result_q <= fin_result;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_alu_divmod_seq.sv
module tb_alu_divmod_seq;
    import alu_divmod_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_op = 1'b0;
    logic        in_is32 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;

    alu_divmod_seq #(.DATA_W(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_is32    (in_is32),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int unsigned acc;
        int unsigned n;
        int          id;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic        is32;
        logic [63:0] res;
        int unsigned n;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, pops one expectation per handshake.
    int unsigned first_cyc = 0;
    bit          seen = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got %h, want no result", out_result);
                end else begin
                    e = sb.pop_front();
                    check64($sformatf("result_%0d", e.id), out_result, e.res);
                    check_int($sformatf("latency_%0d", e.id), first_cyc - e.acc, e.n + 1);
                end
                seen = 1'b0;
            end
        end
    end

    // Called and returns at posedge+2. Expected first out_valid cycle = acc + n + 1.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic op,
                         input logic is32, input logic [63:0] res, input int unsigned n,
                         input bit push, input int id);
        int unsigned k;
        k = 0;
        while (!in_ready && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout_%0d: got in_ready=0, want 1", id);
            return;
        end
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_is32  = is32;
        in_valid = 1'b1;
        if (push) sb.push_back('{res, cyc, n, id});
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        in_a     = '1;
        in_b     = '1;
    endtask

    task automatic drain(input string name);
        int unsigned k;
        k = 0;
        while ((sb.size() != 0 || !in_ready) && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        check_int(name, sb.size(), 0);
    endtask

    vec_t vecs[13];

    initial begin
        int unsigned k;
        int unsigned highs;

        vecs[0]  = '{64'd100, 64'd7, OP_MOD, 1'b0, 64'd2, 64};
        vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64};
        vecs[2]  = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, OP_DIV, 1'b0, 64'd0, 64};
        vecs[3]  = '{64'h1234, 64'd0, OP_MOD, 1'b0, 64'h1234, 0};
        vecs[4]  = '{64'h1234, 64'd0, OP_DIV, 1'b0, 64'd0, 0};
        vecs[5]  = '{64'hDEAD_0000_0000_1234, 64'h1_0000_0000, OP_MOD, 1'b1, 64'h1234, 0};
        vecs[6]  = '{64'hDEAD_0000_0000_0010, 64'h1_0000_0003, OP_DIV, 1'b1, 64'd5, 32};
        vecs[7]  = '{64'hDEAD_0000_0000_0010, 64'h1_0000_0003, OP_MOD, 1'b1, 64'd1, 32};
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'd3, OP_DIV, 1'b0, 64'h2AAA_AAAA_AAAA_AAAA, 64};
        vecs[9]  = '{64'h8000_0000_0000_0000, 64'd3, OP_MOD, 1'b0, 64'd2, 64};
        vecs[10] = '{64'h0000_0000_FFFF_FFFF, 64'h10, OP_DIV, 1'b1, 64'h0FFF_FFFF, 32};
        vecs[11] = '{64'hABCD_0000_FFFF_FFFF, 64'h10, OP_MOD, 1'b1, 64'hF, 32};
        vecs[12] = '{64'd7, 64'h1_0000_0000, OP_DIV, 1'b1, 64'd0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check64("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check64("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check64("rst_out_result", out_result, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Directed vectors, back to back
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].is32, vecs[i].res, vecs[i].n, 1'b1, i);
        end
        drain("drain_vectors");

        // Backpressure: result held for 10 cycles, then released
        out_ready = 1'b0;
        issue(64'd100, 64'd7, OP_DIV, 1'b0, 64'd14, 64, 1'b1, 100);
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk);
            #2;
            k++;
        end
        check64("bp_valid_rise", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check64($sformatf("bp_valid_%0d", i), {63'd0, out_valid}, 64'd1);
            check64($sformatf("bp_result_%0d", i), out_result, 64'd14);
            check64($sformatf("bp_in_ready_%0d", i), {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        check64("bp_in_ready_after", {63'd0, in_ready}, 64'd1);
        check64("bp_valid_after", {63'd0, out_valid}, 64'd0);
        drain("drain_bp");

        // Reset mid-RUN aborts the operation
        issue(64'd12345, 64'd7, OP_DIV, 1'b0, 64'd1763, 64, 1'b0, 200);
        repeat (18) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check64("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check64("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check64("abort_out_result", out_result, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) highs++;
        end
        check_int("abort_no_valid", highs, 0);
        @(posedge clk);
        #2;
        issue(64'd9, 64'd4, OP_MOD, 1'b0, 64'd1, 64, 1'b1, 201);
        drain("drain_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
